// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory access stage
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
  localparam int         REG_W           = 4;

  typedef struct packed {
    logic             pcload;
    logic             regw;
    logic             regmem;
    logic             memw;
    logic [REG_W-1:0] regscr;
  } ctrl_t;

endpackage

// File: rtl/register.sv
// rtl/register.sv - generic enabled register with asynchronous active-high clear
module register #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wen,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= '0;
    else if (wen) out <= in;
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory pipeline stage: word load/store over req/ack,
// stalling upstream and bubbling mwpipe while an access is outstanding
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int N       = 32,
  parameter int M       = REG_W,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_M,
  input  logic         pcload_M,
  input  logic         regw_M,
  input  logic         regmem_M,
  input  logic         memw_M,
  input  logic [M-1:0] regScr_M,
  input  logic [N-1:0] ALUrslt_M,
  input  logic [N-1:0] writedata_M,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         stall_M,
  output logic         fault_M,
  output logic         pcload_W,
  output logic         regw_W,
  output logic         regmem_W,
  output logic [M-1:0] regScr_W,
  output logic [N-1:0] ALUrslt_W,
  output logic [N-1:0] readdata_W
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, state_nx;
  logic [CW-1:0]   wait_cnt;
  logic            req_q, timeout_q;
  logic            memop, misaligned, start, abort, rd_wen;
  ctrl_t           ctrl_d, ctrl_q;
  logic [N-1:0]    addr_q, wdata_q, rdata_q;

  assign memop      = valid_M & (regmem_M | memw_M);
  assign misaligned = (ALUrslt_M[1:0] & WORD_ALIGN_MASK) != 2'b00;
  assign start      = (state == IDLE) && memop && !misaligned;
  // ack in the last permitted cycle takes precedence over the abort
  assign abort      = (state == BUSY) && !mem_ack && (wait_cnt == CW'(TIMEOUT - 1));
  assign rd_wen     = (state == BUSY) && mem_ack && !ctrl_q.memw;

  always_comb begin
    ctrl_d        = '0;
    ctrl_d.pcload = pcload_M;
    ctrl_d.regw   = regw_M;
    ctrl_d.regmem = regmem_M;
    ctrl_d.memw   = memw_M;
    ctrl_d.regscr = regScr_M;
  end

  register #(.W($bits(ctrl_t))) u_ctrl_reg  (.clk(clk), .rst(rst), .wen(start),  .in(ctrl_d),      .out(ctrl_q));
  register #(.W(N))             u_addr_reg  (.clk(clk), .rst(rst), .wen(start),  .in(ALUrslt_M),   .out(addr_q));
  register #(.W(N))             u_wdata_reg (.clk(clk), .rst(rst), .wen(start),  .in(writedata_M), .out(wdata_q));
  register #(.W(N))             u_rdata_reg (.clk(clk), .rst(rst), .wen(rd_wen), .in(mem_rdata),   .out(rdata_q));

  assign mem_req   = req_q;
  assign mem_we    = ctrl_q.memw;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      req_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else if (start) begin
      wait_cnt  <= '0;
      req_q     <= 1'b1;
      timeout_q <= 1'b0;
    end else if (state == BUSY) begin
      if (wait_cnt != {CW{1'b1}}) wait_cnt <= wait_cnt + 1'b1;
      if (mem_ack || abort) req_q <= 1'b0;
      timeout_q <= abort;
    end
  end

  always_comb begin
    state_nx   = state;
    stall_M    = 1'b0;
    fault_M    = 1'b0;
    pcload_W   = 1'b0;
    regw_W     = 1'b0;
    regmem_W   = 1'b0;
    regScr_W   = regScr_M;
    ALUrslt_W  = ALUrslt_M;
    readdata_W = '0;
    case (state)
      IDLE: begin
        if (memop) begin
          stall_M = !misaligned;
          fault_M = misaligned;
          if (!misaligned) state_nx = BUSY;
        end else if (valid_M) begin
          pcload_W = pcload_M;
          regw_W   = regw_M;
          regmem_W = regmem_M;
        end
      end
      BUSY: begin
        stall_M   = 1'b1;
        regScr_W  = ctrl_q.regscr;
        ALUrslt_W = addr_q;
        if (mem_ack || abort) state_nx = DONE;
      end
      DONE: begin
        regScr_W  = ctrl_q.regscr;
        ALUrslt_W = addr_q;
        state_nx  = IDLE;
        if (timeout_q) begin
          fault_M = 1'b1;
        end else begin
          pcload_W   = ctrl_q.pcload;
          regw_W     = ctrl_q.regw;
          regmem_W   = ctrl_q.regmem;
          readdata_W = rdata_q;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
